// File: rtl/seg7_display_ctrl.sv
// N-digit hex 7-segment controller: registered active-low outputs, load handshake,
// per-digit blink and leading-zero blanking. Define SEG7_SCROLL_EN to scroll new values in.
module seg7_display_ctrl #(
    parameter int DIGITS     = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCROLL_DIV = 12500000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    output logic                ready,
    input  logic                lzb,
    input  logic [DIGITS-1:0]   blink_mask,
    output logic [7*DIGITS-1:0] hex_n
);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg7_display_ctrl: DIGITS must be 1..8");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink
        $error("seg7_display_ctrl: BLINK_DIV must be >= 2");
    end
    if (SCROLL_DIV < 1) begin : g_bad_scroll
        $error("seg7_display_ctrl: SCROLL_DIV must be >= 1");
    end

    localparam int BW = $clog2(BLINK_DIV);

    logic [4*DIGITS-1:0] value_q;
    logic [4*DIGITS-1:0] disp_q;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [DIGITS-1:0]   lz_blank;
    logic [7*DIGITS-1:0] hex_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            4'hF: seg_decode = 7'h71;
        endcase
    endfunction

    // Free-running blink prescaler; load activity never disturbs the blink rhythm
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= '0;
        end else if (load && ready) begin
            value_q <= value;
        end
    end

`ifdef SEG7_SCROLL_EN
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    typedef enum logic {IDLE, SCROLL} state_t;

    state_t              state;
    state_t              state_d;
    logic [SW-1:0]       scroll_cnt;
    logic [3:0]          step_cnt;
    logic                step_now;
    logic [4*DIGITS-1:0] scroll_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        ready    = 1'b0;
        step_now = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    state_d = SCROLL;
                end
            end
            SCROLL: begin
                step_now = (scroll_cnt == SW'(SCROLL_DIV - 1));
                if (step_now && step_cnt == 4'(DIGITS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Most significant nibble enters first so the number slides in from the right
    always_comb begin
        scroll_next = disp_q << 4;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(step_cnt) == DIGITS - 1 - i) begin
                scroll_next[3:0] = value_q[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            disp_q     <= '0;
            scroll_cnt <= '0;
            step_cnt   <= '0;
        end else if (state != SCROLL) begin
            scroll_cnt <= '0;
            step_cnt   <= '0;
        end else if (step_now) begin
            scroll_cnt <= '0;
            step_cnt   <= step_cnt + 4'd1;
            disp_q     <= scroll_next;
        end else begin
            scroll_cnt <= scroll_cnt + SW'(1);
        end
    end
`else
    assign ready = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            disp_q <= '0;
        end else begin
            disp_q <= value_q;
        end
    end
`endif

    // Blank leading zeros from the top digit down; digit 0 always shows
    always_comb begin
        logic leading;
        leading  = lzb;
        lz_blank = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (leading && disp_q[4*i +: 4] == 4'h0) begin
                lz_blank[i] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end

    always_comb begin
        hex_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((blink_phase && blink_mask[i]) || lz_blank[i]) begin
                hex_d[7*i +: 7] = 7'h7F;
            end else begin
                hex_d[7*i +: 7] = ~seg_decode(disp_q[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hex_n <= {DIGITS{7'h7F}};
        end else begin
            hex_n <= hex_d;
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl: decode table, lzb, blink timing, reset; scroll when
// SEG7_SCROLL_EN is defined.
`timescale 1ns/1ps
module tb_seg7_display_ctrl;

`ifdef SEG7_SCROLL_EN
    localparam int D = 4;
`else
    localparam int D = 6;
`endif
    localparam int BLINK_DIV  = 4;
    localparam int SCROLL_DIV = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [4*D-1:0] value;
    logic           load;
    logic           ready;
    logic           lzb;
    logic [D-1:0]   blink_mask;
    logic [7*D-1:0] hex_n;

    int assert_count = 0;
    int fail_count   = 0;
    int edge_n       = 0;

    seg7_display_ctrl #(
        .DIGITS    (D),
        .BLINK_DIV (BLINK_DIV),
        .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .value     (value),
        .load      (load),
        .ready     (ready),
        .lzb       (lzb),
        .blink_mask(blink_mask),
        .hex_n     (hex_n)
    );

    always #5 clk = ~clk;

    // edge_n counts edges since reset release; edge 1 is the first edge with reset_n=1
    task automatic tick();
        @(posedge clk);
        #1;
        if (reset_n) edge_n++;
        else edge_n = 0;
    endtask

    task automatic applyStimulus(input logic rst_n, input logic [4*D-1:0] v, input logic ld,
                                 input logic lz, input logic [D-1:0] mask);
        reset_n    = rst_n;
        value      = v;
        load       = ld;
        lzb        = lz;
        blink_mask = mask;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7*D-1:0] rep(input logic [6:0] d);
        logic [7*D-1:0] r;
        for (int i = 0; i < D; i++) r[7*i +: 7] = d;
        return r;
    endfunction

    function automatic logic [6:0] seg_n(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SEG7_SCROLL_EN
    function automatic logic [7*D-1:0] hex_of(input logic [4*D-1:0] v);
        logic [7*D-1:0] r;
        for (int i = 0; i < D; i++) r[7*i +: 7] = seg_n(v[4*i +: 4]);
        return r;
    endfunction

    task automatic runScroll();
        logic [15:0] steps [5];
        int          idx;
        steps[0] = 16'h0000;
        steps[1] = 16'h0001;
        steps[2] = 16'h0012;
        steps[3] = 16'h0123;
        steps[4] = 16'h1234;
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, '0);
        checkOutput("scroll_ready_k0", 64'(ready), 64'd0);
        checkOutput("scroll_hex_k0", 64'(hex_n), 64'(rep(7'h40)));
        for (int k = 1; k <= 9; k++) begin
            load  = (k == 3);
            value = (k == 3) ? 16'hFFFF : 16'h1234;
            tick();
            idx = (k - 1 >= 8) ? 4 : (k - 1) / 2;
            checkOutput($sformatf("scroll_ready_k%0d", k), 64'(ready), 64'(k >= 8));
            checkOutput($sformatf("scroll_hex_k%0d", k), 64'(hex_n), 64'(hex_of(steps[idx])));
        end
        load = 1'b0;
        tick();
        checkOutput("scroll_hold", 64'(hex_n), 64'(hex_of(16'h1234)));
    endtask
`else
    typedef struct {
        logic [23:0] v;
        logic        lz;
        logic [41:0] exp;
    } vec_t;

    function automatic logic [41:0] pack6(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic runMain();
        vec_t        tbl [10];
        logic [41:0] prev_exp;
        logic        prev_lz;
        logic        phase;

        tbl[0] = '{24'h0001F8, 1'b0, pack6(7'h40, 7'h40, 7'h40, 7'h79, 7'h0E, 7'h00)};
        tbl[1] = '{24'h0001F8, 1'b1, pack6(7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h0E, 7'h00)};
        tbl[2] = '{24'h000000, 1'b1, pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)};
        tbl[3] = '{24'h000000, 1'b0, pack6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)};
        tbl[4] = '{24'h123456, 1'b0, pack6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02)};
        tbl[5] = '{24'h789ABC, 1'b0, pack6(7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46)};
        tbl[6] = '{24'hDEF000, 1'b1, pack6(7'h21, 7'h06, 7'h0E, 7'h40, 7'h40, 7'h40)};
        tbl[7] = '{24'h0A0B00, 1'b1, pack6(7'h7F, 7'h08, 7'h40, 7'h03, 7'h40, 7'h40)};
        tbl[8] = '{24'h00000F, 1'b1, pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E)};
        tbl[9] = '{24'h010000, 1'b1, pack6(7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40)};

        prev_exp = rep(7'h40);
        prev_lz  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, tbl[i].v, 1'b1, tbl[i].lz, '0);
            load = 1'b0;
            tick();
            if (tbl[i].lz == prev_lz)
                checkOutput($sformatf("latency_v%0d", i), 64'(hex_n), 64'(prev_exp));
            tick();
            checkOutput($sformatf("decode_v%0d", i), 64'(hex_n), 64'(tbl[i].exp));
            checkOutput($sformatf("ready_v%0d", i), 64'(ready), 64'd1);
            prev_exp = tbl[i].exp;
            prev_lz  = tbl[i].lz;
        end

        // Blink: phase before edge n is ((n-1)/BLINK_DIV) mod 2, counted from reset release
        applyStimulus(1'b1, 24'h000008, 1'b1, 1'b0, '0);
        load = 1'b0;
        tick();
        tick();
        blink_mask = 6'b000001;
        for (int k = 0; k < 16; k++) begin
            tick();
            phase = (((edge_n - 1) / BLINK_DIV) % 2) == 1;
            checkOutput($sformatf("blink_e%0d", edge_n), 64'(hex_n),
                        64'(pack6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, phase ? 7'h7F : 7'h00)));
        end

        applyStimulus(1'b0, 24'hABCDEF, 1'b1, 1'b0, '0);
        checkOutput("midreset_hex", 64'(hex_n), 64'(rep(7'h7F)));
        checkOutput("midreset_ready", 64'(ready), 64'd1);
        applyStimulus(1'b1, 24'hABCDEF, 1'b0, 1'b1, '0);
        checkOutput("release_lzb", 64'(hex_n),
                    64'(pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)));
        applyStimulus(1'b1, 24'hABCDEF, 1'b0, 1'b0, '0);
        checkOutput("release_nolzb", 64'(hex_n), 64'(rep(7'h40)));
        tick();
        checkOutput("load_ignored_in_reset", 64'(hex_n), 64'(rep(7'h40)));
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        value      = '0;
        load       = 1'b0;
        lzb        = 1'b0;
        blink_mask = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("reset_hex_%0d", i), 64'(hex_n), 64'(rep(7'h7F)));
            checkOutput($sformatf("reset_ready_%0d", i), 64'(ready), 64'd1);
        end
        applyStimulus(1'b1, '0, 1'b0, 1'b0, '0);
        checkOutput("release_hex", 64'(hex_n), 64'(rep(7'h40)));
        checkOutput("release_ready", 64'(ready), 64'd1);
`ifdef SEG7_SCROLL_EN
        runScroll();
`else
        runMain();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
Parametrised N-digit hexadecimal 7-segment display controller. Generalises the two-digit static decoder top: configurable digit count, registered outputs, load handshake, per-digit blinking and leading-zero blanking. Sits between user logic (counters, ALU results, switch values) and the board HEXn_n pins.

Parameters:
DIGITS, 6, number of 7-segment digits driven (1..8)
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2)
SCROLL_DIV, 12500000, clock cycles per scroll step (used only with SEG7_SCROLL_EN, >=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
value  input  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 rightmost)
load  input  1  capture value when load && ready
ready  output  1  controller accepts a load this cycle
lzb  input  1  leading-zero blanking enable (level, sampled every cycle)
blink_mask  input  DIGITS  bit i=1: digit i blinks
hex_n  output  7*DIGITS  active-low segments; hex_n[7i+6:7i] = digit i, bit order g f e d c b a

Behaviour:
- Reset (reset_n=0 at an edge): value_q=0, disp_q=0, blink prescaler=0, blink_phase=0, state=IDLE, ready=1, every hex_n digit=7'h7F (all off).
- Decode (positive logic, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; hex_n is the bitwise inverse. Blank digit = hex_n 7'h7F.
- Load: on edge with load=1 and ready=1, value_q<=value. load while ready=0 is ignored (no queuing).
- Display register disp_q: without scroll, disp_q<=value_q every cycle.
- hex_n registered from disp_q, blink_phase, blink_mask, lzb. Latency: load sampled at edge t -> new digits on hex_n after edge t+2.
- Blink: prescaler counts 0..BLINK_DIV-1, wraps; at wrap blink_phase toggles. Digit i blank when blink_phase=1 and blink_mask[i]=1. Prescaler free-runs, unaffected by load.
- Leading-zero blanking: when lzb=1, digits from DIGITS-1 downward whose nibble is 0 are blanked until first nonzero nibble; digit 0 never blanked by lzb. Blink blanking ORs with lzb blanking.
- After reset release: first edge with reset_n=1 shows decoded disp_q (all "0", or only digit 0 when lzb=1).
- Reset mid-operation (including mid-scroll) returns all state to reset values on that edge.

Optional Feature:
SEG7_SCROLL_EN defined: accepted load enters state SCROLL, ready=0. Every SCROLL_DIV cycles one step: disp_q <= {disp_q shifted up one digit, new digit 0 = value_q nibble DIGITS-k} for step k=1..DIGITS. After step DIGITS disp_q==value_q, state=IDLE, ready=1 next cycle. Step counter starts at 0 on acceptance; first step SCROLL_DIV cycles after acceptance. Blink/lzb apply to disp_q during scroll.
SEG7_SCROLL_EN undefined: no SCROLL state, ready constantly 1 after reset, SCROLL_DIV unused, disp_q follows value_q immediately.

Test Plan:
- DIGITS=6, reset 3 cycles -> hex_n all 7'h7F during reset; first cycle after release each digit 7'h40; ready=1.
- load value=24'h0001F8, lzb=0 -> after 2 edges digits 5..0 = 40,40,40,79,0E,00.
- Same value, lzb=1 -> digits 5..3 = 7F, digits 2..0 = 79,0E,00; value=0 -> only digit 0 = 40.
- BLINK_DIV=4, blink_mask=6'b000001, value=24'h000008 -> digit 0 alternates 00 / 7F every 4 cycles; other digits steady 40.
- load pulsed with reset_n=0 mid-stream -> state and outputs return to reset values on that edge, load ignored.
- SEG7_SCROLL_EN, DIGITS=4, SCROLL_DIV=2, load 16'h1234 -> ready=0 for 8 cycles, disp_q steps 0001,0012,0123,1234; load=16'hFFFF during scroll ignored; ready=1 afterwards.
